fixed_acc: RTL
==============

# fixed_acc

Streaming saturating accumulator for sign-magnitude fixed-point values. It is the sequential successor to the combinational two-operand fixed adder, parametrised in word width and guard width. It sums a variable-length vector of terms delimited by `in_last`, then emits one saturated sign-magnitude result with an overflow flag. It sits behind the LSTM gate multipliers and reduces dot-product terms before activation.

## Interface
Parameters:
- `WIDTH`, 12: total word bits (1 sign + `INT_BITS` + `FRAC_BITS`)
- `FRAC_BITS`, 6: fractional bits. Informational only; it does not affect the arithmetic.
- `INT_BITS`, 5: integer bits. `WIDTH` must equal 1 + `INT_BITS` + `FRAC_BITS`.
- `GUARD`, 4: extra accumulator bits above `WIDTH`. Used only without the macro.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `in_valid`  in  1  term valid
- `in_ready`  out  1  block can accept a term
- `in_data`  in  `WIDTH`  term, sign-magnitude: bit `WIDTH-1` is the sign
- `in_last`  in  1  this term closes the vector
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts the result
- `out_data`  out  `WIDTH`  sum, sign-magnitude, saturated
- `out_ovf`  out  1  overflow occurred for this vector

## Operation
- State machine: ACC and OUT. Reset state is ACC with the accumulator at 0.
  - ACC: `in_ready`=1. Each input handshake (`in_valid` & `in_ready`) adds the term to the accumulator.
  - ACC → OUT on a handshake with `in_last`=1. The last term is included in the sum.
  - OUT: `in_ready`=0 and `out_valid`=1. `out_data` and `out_ovf` are registered and held stable.
  - OUT → ACC on `out_valid` & `out_ready`. The accumulator and sticky overflow clear for the next vector.
- Term conversion: sign-magnitude to two's complement. Negative zero (`{1'b1, 0…}`) is treated as 0.
- MAX_MAG = 2^(`WIDTH`-1)-1.
- Result conversion:
  - Magnitude = min(|acc|, MAX_MAG).
  - Sign = sign of acc; the sign is 0 when the magnitude is 0.
  - `out_ovf` = sticky overflow, or |final acc| > MAX_MAG.
- A vector of one term (`in_last` on the first term) is legal and passes the term through; negative zero outputs as 0.
- Idle gaps (`in_valid`=0) in ACC hold state.
- `in_last` is ignored when `in_valid`=0.
- Reset asserted mid-vector or mid-OUT aborts immediately. The partial sum is discarded and no result is emitted.

## Timing
- Reset values: `in_ready`=1 (ACC), `out_valid`=0, `out_data`=0, `out_ovf`=0.
- Latency: `out_valid` rises on the first edge after the `in_last` handshake edge.
- Throughput: one term per cycle in ACC. There is exactly one bubble cycle per vector: `in_ready` is low for at least one cycle while in OUT.
- First term of the next vector: accepted no earlier than the cycle after the output handshake.
- `in_ready` is a pure function of state. It is combinational, and `in_valid` does not combinationally affect it.

## Configuration
- `FIXED_ACC_STEP_SAT_EN` defined:
  - Accumulator is `WIDTH`+1 bits.
  - After every add the accumulator is clipped to ±MAX_MAG, and the sticky overflow is set if clipping occurred.
  - Results are bit-identical to chaining the two-operand saturating adder.
- Not defined:
  - Accumulator is `WIDTH`+`GUARD` bits. Intermediate sums may exceed MAX_MAG without penalty.
  - Only the accumulator's own range clips and sets the sticky flag. In practice this cannot occur for vectors ≤ 2^`GUARD` terms.
  - Saturation to MAX_MAG is applied at output only.

## Test plan
Defaults throughout.
- Reset release: after `rst` falls, expect `in_ready`=1, `out_valid`=0, `out_data`=0x000, `out_ovf`=0.
- Mixed signs: send 0x040, 0x040, 0x840(last) → `out_data`=0x040 (+1.0), `out_ovf`=0, one cycle after the last handshake. Then send 0x800(last) alone → 0x000, `out_ovf`=0.
- Saturation: send 0x7FF, 0x001(last) → 0x7FF, `out_ovf`=1 (both modes). Send 0xFFF, 0x801(last) → 0xFFF, `out_ovf`=1.
- Guard vs step mode: send 0x7FF, 0x7FF, 0xFFF, 0xFFF(last).
  - Without the macro: 0x000, `out_ovf`=0.
  - With `FIXED_ACC_STEP_SAT_EN`: 0xFFF (-2047), `out_ovf`=1.
- Backpressure: hold `out_ready`=0 for 3 cycles after `out_valid`. `out_data`/`out_ovf` stay stable and `in_ready`=0 throughout, with `in_valid`=1 driven. Nothing is accepted until the cycle after the output handshake.
- Reset mid-vector: send 0x100, 0x100, pulse `rst` asynchronously between clock edges, then send 0x040(last) → 0x040, `out_ovf`=0. There is no stale result.

Source files
------------

// File: rtl/fixed_acc.sv
// -----------------------------------------------------------------------------
// fixed_acc
// Streaming saturating accumulator for sign-magnitude fixed-point terms.
// It sums a vector of terms closed by in_last, then presents one saturated
// sign-magnitude result plus an overflow flag until the consumer takes it.
//
// Configuration macro: FIXED_ACC_STEP_SAT_EN
//   defined   : WIDTH+1 bit accumulator, clipped to +/-MAX_MAG after every add
//               (bit-identical to chaining the two-operand saturating adder).
//   undefined : WIDTH+GUARD bit accumulator, saturation applied at output only.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   term valid
//   in_ready   block can accept a term (high only while accumulating)
//   in_data    sign-magnitude term, bit WIDTH-1 is the sign
//   in_last    term closes the vector (ignored unless in_valid)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   saturated sign-magnitude sum
//   out_ovf    overflow occurred for this vector
// -----------------------------------------------------------------------------
module fixed_acc #(
  parameter int WIDTH     = 12,
  parameter int FRAC_BITS = 6,
  parameter int INT_BITS  = 5,
  parameter int GUARD     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  // Magnitude width.
  localparam int MW = WIDTH - 1;

`ifdef FIXED_ACC_STEP_SAT_EN
  localparam int AW = WIDTH + 1;
`else
  localparam int AW = WIDTH + GUARD;
`endif

  // All signed arithmetic is carried one bit wider than the accumulator so the
  // raw sum of accumulator and term can never wrap.
  localparam logic signed [AW:0] MAX_MAG = {{(AW - MW + 1){1'b0}}, {MW{1'b1}}};
`ifdef FIXED_ACC_STEP_SAT_EN
  localparam logic signed [AW:0] LIM     = MAX_MAG;
`else
  localparam logic signed [AW:0] LIM     = {2'b00, {(AW - 1){1'b1}}};
`endif
  localparam logic signed [AW:0] NEG_LIM = -LIM;

  if (WIDTH != 1 + INT_BITS + FRAC_BITS || GUARD < 1) begin : g_bad_params
    $error("fixed_acc: WIDTH must equal 1+INT_BITS+FRAC_BITS and GUARD >= 1");
  end

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic signed [AW-1:0]  r_acc;
  logic                  r_sticky;
  logic [WIDTH-1:0]      r_out_data;
  logic                  r_out_ovf;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic signed [AW:0]    w_term_pos;
  logic signed [AW:0]    w_term;
  logic signed [AW:0]    w_sum;
  logic signed [AW:0]    w_acc_next;
  logic                  w_clip;
  logic signed [AW:0]    w_abs;
  logic                  w_big;
  logic [MW-1:0]         w_res_mag;
  logic                  w_res_sign;
  logic                  w_res_ovf;

  // Handshake flags are pure functions of state, never of in_valid.
  assign in_ready   = (r_state == S_ACC);
  assign out_valid  = (r_state == S_OUT);
  assign out_data   = r_out_data;
  assign out_ovf    = r_out_ovf;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Sign-magnitude to two's complement; negative zero negates to plain zero.
  assign w_term_pos = {{(AW - MW + 1){1'b0}}, in_data[MW-1:0]};
  assign w_term     = in_data[WIDTH-1] ? -w_term_pos : w_term_pos;
  assign w_sum      = {r_acc[AW-1], r_acc} + w_term;

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_acc_next = w_sum;
    w_clip     = 1'b0;
    if (w_sum > LIM) begin
      w_acc_next = LIM;
      w_clip     = 1'b1;
    end else if (w_sum < NEG_LIM) begin
      w_acc_next = NEG_LIM;
      w_clip     = 1'b1;
    end
  end

  // Result conversion of the post-add value, captured on the closing term.
  assign w_abs      = w_acc_next[AW] ? -w_acc_next : w_acc_next;
  assign w_big      = (w_abs > MAX_MAG);
  assign w_res_mag  = w_big ? {MW{1'b1}} : w_abs[MW-1:0];
  assign w_res_sign = w_acc_next[AW] & (w_res_mag != '0);
  assign w_res_ovf  = r_sticky | w_clip | w_big;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ACC;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACC:   if (w_in_fire && in_last) w_state_next = S_OUT;
      S_OUT:   if (w_out_fire)           w_state_next = S_ACC;
      default: w_state_next = S_ACC;
    endcase
  end

  // NOTE: these are plain registers, not memories, so all of them take the
  // asynchronous reset; a reset mid-vector must discard the partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_sticky   <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else if (w_in_fire) begin
      r_acc    <= w_acc_next[AW-1:0];
      r_sticky <= r_sticky | w_clip;
      if (in_last) begin
        r_out_data <= {w_res_sign, w_res_mag};
        r_out_ovf  <= w_res_ovf;
      end
    end else if (w_out_fire) begin
      // Result handed off: start the next vector from zero.
      r_acc    <= '0;
      r_sticky <= 1'b0;
    end
  end

endmodule
